// File: rtl/twisted_ring_counter.sv
// Johnson / ring shift counter with load, illegal-state recovery,
// decoded position index and wrap pulse.
module twisted_ring_counter #(
  parameter int WIDTH = 4,
  localparam int IDXW = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic [IDXW-1:0]  idx,
  output logic             wrap,
  output logic             err
);

  function automatic logic is_legal(
    input logic [WIDTH-1:0] c,
    input logic             m
  );
    int n;
    int t;
    n = 0;
    t = 0;
    for (int i = 0; i < WIDTH; i++)
      n += int'(c[i]);
    for (int i = 0; i < WIDTH - 1; i++)
      if (c[i] != c[i+1]) t++;
    return m ? (n == 1) : (t <= 1);
  endfunction

  // Johnson: MSB-side run of k ones -> k, LSB-side run of m ones -> 2W-m
  function automatic logic [IDXW-1:0] decode(
    input logic [WIDTH-1:0] c,
    input logic             m
  );
    int n;
    int pos;
    n = 0;
    pos = 0;
    for (int i = 0; i < WIDTH; i++) begin
      n += int'(c[i]);
      if (c[i]) pos = i;
    end
    if (!is_legal(c, m))
      return '0;
    if (m)
      return (pos == 0) ? '0 : IDXW'(WIDTH - pos);
    if (c[WIDTH-1] || n == 0)
      return IDXW'(n);
    return IDXW'(2 * WIDTH - n);
  endfunction

  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] nxt;
  logic [IDXW-1:0]  cur;
  logic [IDXW-1:0]  maxi;
  logic             nwrap;
  logic             nerr;

  always_comb begin
    home  = {{(WIDTH-1){1'b0}}, mode};
    cur   = decode(count, mode);
    maxi  = mode ? IDXW'(WIDTH - 1) : IDXW'(2 * WIDTH - 1);
    nxt   = count;
    nwrap = 1'b0;
    nerr  = 1'b0;
    if (!is_legal(count, mode)) begin
      nxt  = home;
      nerr = 1'b1;
    end else begin
      unique case ({mode, dir})
        2'b00: nxt = {~count[0], count[WIDTH-1:1]};
        2'b01: nxt = {count[WIDTH-2:0], ~count[WIDTH-1]};
        2'b10: nxt = {count[0], count[WIDTH-1:1]};
        2'b11: nxt = {count[WIDTH-2:0], count[WIDTH-1]};
        default: nxt = count;
      endcase
      nwrap = dir ? (cur == '0) : (cur == maxi);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= home;
      idx   <= '0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (load) begin
      count <= load_value;
      idx   <= decode(load_value, mode);
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (enable) begin
      count <= nxt;
      idx   <= decode(nxt, mode);
      wrap  <= nwrap;
      err   <= nerr;
    end else begin
      wrap  <= 1'b0;
      err   <= 1'b0;
    end
  end

endmodule

// File: doc/twisted_ring_counter.md
# twisted_ring_counter

Parametrised shift-register counter, the general-purpose successor of the fixed 4-bit Johnson counter in the sequential-counters library. It runs in Johnson (twisted-ring, period 2·WIDTH) or plain ring (one-hot, period WIDTH) mode and counts in either direction. It also supports parallel load, detects illegal states and corrects them, and provides a decoded position index plus a wrap pulse. It is intended as a phase/sequence generator for timing and multiplexing logic elsewhere in the lab designs.

## Interface
- WIDTH, 4, register width; legal range ≥ 2.
- IDXW (localparam), $clog2(2·WIDTH), width of `idx`.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  advance one step when high.
- dir  in  1  0 = up (shift right), 1 = down (shift left).
- mode  in  1  0 = Johnson, 1 = ring.
- load  in  1  parallel load of `load_value`.
- load_value  in  WIDTH  value written by `load`.
- count  out  WIDTH  counter register.
- idx  out  IDXW  registered position index of `count`.
- wrap  out  1  one-cycle pulse on sequence wrap.
- err  out  1  one-cycle pulse when an illegal state is corrected.

## Operation
- Home value H(mode): Johnson = all zeros; ring = 0…01 (bit 0 set).
- Priority per edge: reset > load > enable > hold.
- reset: count = H(mode), idx = 0, wrap = 0, err = 0.
- load: count = load_value and idx = decode(load_value); wrap = 0, err = 0. Illegal values are accepted as-is.
- enable with a legal count:
  - Johnson up: {~count[0], count[W-1:1]}.
  - Johnson down: {count[W-2:0], ~count[W-1]}.
  - Ring up: {count[0], count[W-1:1]}.
  - Ring down: {count[W-2:0], count[W-1]}.
- Legal states:
  - Johnson: k ones followed by W−k zeros (k = 0..W), or k zeros followed by W−k ones (k = 1..W−1). This gives 2W states.
  - Ring: exactly one bit set.
- enable with an illegal count (for the current `mode`): count = H(mode), idx = 0, err = 1, wrap = 0.
- A mode change takes effect on the next enabled step. A state that is legal in the old mode but illegal in the new one is corrected as described above.
- decode, Johnson (W=4, up order): 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7. In general, MSB-side ones run k → idx k; LSB-side ones run of length m → idx 2W−m.
- decode, ring: 0…01 = 0; bit b set (b ≥ 1) → idx W−b.
- decode, illegal state: idx = 0.
- wrap = 1 for an enabled legal step from idx max to 0 (up), or from 0 to max (down). max = 2W−1 in Johnson, W−1 in ring.
- wrap and err are never high together; both are 0 on any cycle without an enabled step.
- enable low: count and idx hold; wrap = err = 0.

## Timing
- All outputs are registered and update on the same rising edge. `idx`, `wrap` and `err` are consistent with the `count` value of that same cycle.
- Latency is one cycle from enable, load or reset sampled high to the new `count`.
- There are no combinational paths from inputs to outputs.
- Reset asserted mid-sequence returns count to home on the next edge, regardless of enable, load or dir. Counting resumes the first enabled cycle after reset deasserts.
- dir and mode may change every cycle; the value sampled on the step edge applies.
- load and enable high together: load wins and no step occurs.

## Test plan
- Johnson up, W=4: reset, then enable for 9 cycles. Required count sequence: 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000, 1000. idx runs 1…7, 0, 1. wrap is high only on the 0000 cycle.
- Johnson down, W=4: from 0000 with dir=1, require 0001 (idx 7, wrap=1), then 0011, then 0111.
- Ring mode, W=4: reset with mode=1 gives 0001. Up steps give 1000, 0100, 0010, 0001, with wrap on the return to 0001. Down from 0001 gives 0010, with wrap.
- Illegal load, Johnson: load 0101 → count 0101, idx 0, err 0. The next enabled step gives 0000 with err = 1 for one cycle and wrap = 0.
- Mode switch: Johnson at 1100, set mode=1 and enable. Require 0001 and err = 1. The following step gives 1000 with err = 0.
- Reset and hold: reset at idx 5 gives 0000 next edge regardless of enable. With enable=0 for 3 cycles, count holds and wrap = err = 0. With W=6 Johnson, 12 enabled steps return to 000000 with exactly one wrap pulse.
